mem_access_stage: RTL and testbench

MEM pipeline stage between the EX/MEM and MEM/WB registers. Issues loads/stores to a word-wide

---
 rtl/mem_access_stage_pkg.sv | 62 ++++++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and encodings for the MEM stage: access size/sign, error codes, FSM states,
// plus helpers for misalignment detection, byte enables and store-lane replication.
package mem_access_stage_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  write_reg;
    logic        halt;
  } mem_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
    logic        halt;
    logic [1:0]  err;
  } mem_res_t;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
    case (op[1:0])
      SZ_BYTE: byte_en = 4'b0001 << a;
      SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] d);
    case (op[1:0])
      SZ_BYTE: lane_data = {4{d[7:0]}};
      SZ_HALF: lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half lane from a read word
// and sign- or zero-extends it; word accesses pass through untouched.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mem_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (mem_op[1:0])
      SZ_BYTE: data = mem_op[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = mem_op[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one outstanding load/store over a req/ready handshake, stalls
// upstream while waiting, and registers aligned results (or error pulses) into MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteIn,
  input  logic              MemtoRegIn,
  input  logic              MemWriteIn,
  input  logic [2:0]        MemOpIn,
  input  logic [31:0]       ALUResultIn,
  input  logic [4:0]        WriteRegIn,
  input  logic [31:0]       WriteDataIn,
  input  logic              HaltIn,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              Stall,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [31:0]       ReadDataOut,
  output logic [31:0]       ALUResultOut,
  output logic [4:0]        WriteRegOut,
  output logic              HaltOut,
  output logic [1:0]        Err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t          op_q, op_d;
  mem_res_t         res_q, res_d;

  mem_op_t     in_op;
  logic        in_memop;
  logic        in_misal;
  logic        timeout_hit;
  logic        stall_c;
  logic [31:0] load_data;

  assign in_op = '{reg_write: RegWriteIn, memto_reg: MemtoRegIn, mem_write: MemWriteIn,
                   mem_op: MemOpIn, addr: ALUResultIn, wdata: WriteDataIn,
                   write_reg: WriteRegIn, halt: HaltIn};
  assign in_memop    = MemtoRegIn | MemWriteIn;
  assign in_misal    = is_misaligned(MemOpIn, ALUResultIn[1:0]);
  // A completion arriving on the last allowed cycle wins over the abort.
  assign timeout_hit = (state_q == S_REQ) && !dmem_ready && (cnt_q == CNT_LAST);

  mem_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (op_q.addr[1:0]),
    .mem_op  (op_q.mem_op),
    .data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (in_memop && !in_misal) begin
          state_d = S_REQ;
          cnt_d   = '0;
          op_d    = in_op;
        end
      end
      S_REQ: begin
        if (dmem_ready || timeout_hit) state_d = S_IDLE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d   = '0;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_memop) begin
          res_d = '{reg_write: RegWriteIn, memto_reg: MemtoRegIn, read_data: 32'b0,
                    alu_result: ALUResultIn, write_reg: WriteRegIn, halt: HaltIn,
                    err: ERR_NONE};
        end else if (in_misal) begin
          res_d = '{reg_write: 1'b0, memto_reg: 1'b0, read_data: 32'b0,
                    alu_result: ALUResultIn, write_reg: WriteRegIn, halt: HaltIn,
                    err: ERR_MISALIGN};
        end else begin
          stall_c = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem_ready) begin
          res_d = '{reg_write: op_q.reg_write, memto_reg: op_q.memto_reg,
                    read_data: op_q.memto_reg ? load_data : 32'b0,
                    alu_result: op_q.addr, write_reg: op_q.write_reg, halt: op_q.halt,
                    err: ERR_NONE};
        end else if (timeout_hit) begin
          res_d = '{reg_write: 1'b0, memto_reg: 1'b0, read_data: 32'b0,
                    alu_result: op_q.addr, write_reg: op_q.write_reg, halt: op_q.halt,
                    err: ERR_TIMEOUT};
        end else begin
          stall_c = 1'b1;
        end
      end
      default: stall_c = 1'b0;
    endcase
  end

  assign Stall      = stall_c & reset;
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = op_q.mem_write;
  assign dmem_addr  = op_q.addr[ADDR_W+1:2];
  assign dmem_be    = byte_en(op_q.mem_op, op_q.addr[1:0]);
  assign dmem_wdata = lane_data(op_q.mem_op, op_q.wdata);

  assign RegWriteOut  = res_q.reg_write;
  assign MemtoRegOut  = res_q.memto_reg;
  assign ReadDataOut  = res_q.read_data;
  assign ALUResultOut = res_q.alu_result;
  assign WriteRegOut  = res_q.write_reg;
  assign HaltOut      = res_q.halt;
  assign Err          = res_q.err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table-driven bench for mem_access_stage with a bench-driven memory responder
// (per-vector ready delay) plus hand sequences for reset state and reset during a request.
module tb_mem_access_stage;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 4;
  localparam int NVEC    = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              RegWriteIn, MemtoRegIn, MemWriteIn, HaltIn;
  logic [2:0]        MemOpIn;
  logic [31:0]       ALUResultIn, WriteDataIn;
  logic [4:0]        WriteRegIn;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata, dmem_rdata;
  logic              Stall, RegWriteOut, MemtoRegOut, HaltOut;
  logic [31:0]       ReadDataOut, ALUResultOut;
  logic [4:0]        WriteRegOut;
  logic [1:0]        Err;

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RegWriteIn(RegWriteIn), .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
    .MemOpIn(MemOpIn), .ALUResultIn(ALUResultIn), .WriteRegIn(WriteRegIn),
    .WriteDataIn(WriteDataIn), .HaltIn(HaltIn),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .Stall(Stall), .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut), .WriteRegOut(WriteRegOut),
    .HaltOut(HaltOut), .Err(Err)
  );

  typedef struct {
    logic        rw, mtr, mw;
    logic [2:0]  op;
    logic [31:0] addr, wd;
    logic [4:0]  wreg;
    logic        halt;
    logic [31:0] rdata;
    int          delay;
    logic        exp_req, exp_we;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rd;
    logic [1:0]  exp_err;
    logic        exp_rw, exp_mtr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[NVEC];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_bubble();
    RegWriteIn = 0; MemtoRegIn = 0; MemWriteIn = 0; MemOpIn = 0;
    ALUResultIn = 0; WriteRegIn = 0; WriteDataIn = 0; HaltIn = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   stall_cnt, req_cycles, cyc;
    bit   req_seen, done;
    v = vecs[i];
    stall_cnt = 0; req_cycles = 0; cyc = 0; req_seen = 0; done = 0;
    @(negedge clk);
    RegWriteIn = v.rw; MemtoRegIn = v.mtr; MemWriteIn = v.mw; MemOpIn = v.op;
    ALUResultIn = v.addr; WriteDataIn = v.wd; WriteRegIn = v.wreg; HaltIn = v.halt;
    dmem_rdata = v.rdata;
    while (!done && cyc < 30) begin
      if (dmem_req) begin
        if (!req_seen) begin
          req_seen = 1;
          chk($sformatf("v%0d_addr", i), 32'(dmem_addr), 32'(v.exp_addr));
          chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v.exp_be));
          chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v.exp_we));
          chk($sformatf("v%0d_wdata", i), dmem_wdata, v.exp_wdata);
        end
        dmem_ready = (req_cycles == v.delay);
        req_cycles++;
      end else begin
        dmem_ready = 0;
      end
      #1;
      if (Stall) stall_cnt++;
      else done = 1;
      @(posedge clk); #1;
      if (!done) begin
        chk($sformatf("v%0d_wait_rw", i), 32'(RegWriteOut), 32'd0);
        chk($sformatf("v%0d_wait_err", i), 32'(Err), 32'd0);
        @(negedge clk);
      end
      cyc++;
    end
    dmem_ready = 0;
    if (!done) chk($sformatf("v%0d_bound_done", i), 32'd0, 32'd1);
    chk($sformatf("v%0d_stall_cycles", i), 32'(stall_cnt), 32'(v.exp_stall));
    chk($sformatf("v%0d_req_seen", i), 32'(req_seen), 32'(v.exp_req));
    chk($sformatf("v%0d_rdata_out", i), ReadDataOut, v.exp_rd);
    chk($sformatf("v%0d_err", i), 32'(Err), 32'(v.exp_err));
    chk($sformatf("v%0d_regwrite", i), 32'(RegWriteOut), 32'(v.exp_rw));
    chk($sformatf("v%0d_memtoreg", i), 32'(MemtoRegOut), 32'(v.exp_mtr));
    chk($sformatf("v%0d_alu_out", i), ALUResultOut, v.addr);
    chk($sformatf("v%0d_wreg_out", i), 32'(WriteRegOut), 32'(v.wreg));
    chk($sformatf("v%0d_halt_out", i), 32'(HaltOut), 32'(v.halt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rw"}, 32'(RegWriteOut), 0);
    chk({tag, "_mtr"}, 32'(MemtoRegOut), 0);
    chk({tag, "_rd"}, ReadDataOut, 0);
    chk({tag, "_alu"}, ALUResultOut, 0);
    chk({tag, "_wreg"}, 32'(WriteRegOut), 0);
    chk({tag, "_halt"}, 32'(HaltOut), 0);
    chk({tag, "_err"}, 32'(Err), 0);
    chk({tag, "_req"}, 32'(dmem_req), 0);
    chk({tag, "_stall"}, 32'(Stall), 0);
  endtask

  initial begin
    //           rw mtr mw op      addr           wd             wreg   h  rdata          dly  req we addr     be       wdata          rd             err    rw mtr stall
    vecs[0]  = '{1, 1, 0, 3'b010, 32'h00000010, 32'h0,         5'd2,  0, 32'hDEADBEEF, 0,  1, 0, 10'h004, 4'b1111, 32'h0,         32'hDEADBEEF, 2'b00, 1, 1, 1};
    vecs[1]  = '{1, 1, 0, 3'b000, 32'h00000013, 32'h0,         5'd3,  0, 32'h80112233, 0,  1, 0, 10'h004, 4'b1000, 32'h0,         32'hFFFFFF80, 2'b00, 1, 1, 1};
    vecs[2]  = '{1, 1, 0, 3'b100, 32'h00000013, 32'h0,         5'd3,  0, 32'h80112233, 0,  1, 0, 10'h004, 4'b1000, 32'h0,         32'h00000080, 2'b00, 1, 1, 1};
    vecs[3]  = '{0, 0, 1, 3'b001, 32'h00000006, 32'h0000ABCD,  5'd0,  0, 32'h0,        0,  1, 1, 10'h001, 4'b1100, 32'hABCDABCD,  32'h0,        2'b00, 0, 0, 1};
    vecs[4]  = '{1, 1, 0, 3'b010, 32'h00000002, 32'h0,         5'd4,  0, 32'h0,        0,  0, 0, 10'h000, 4'b0000, 32'h0,         32'h0,        2'b01, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 3'b000, 32'h00000000, 32'h0,         5'd0,  0, 32'h0,        0,  0, 0, 10'h000, 4'b0000, 32'h0,         32'h0,        2'b00, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 3'b000, 32'h12345678, 32'h0,         5'd7,  0, 32'h0,        0,  0, 0, 10'h000, 4'b0000, 32'h0,         32'h0,        2'b00, 1, 0, 0};
    vecs[7]  = '{1, 1, 0, 3'b001, 32'h00000022, 32'h0,         5'd8,  0, 32'h80017FFF, 3,  1, 0, 10'h008, 4'b1100, 32'h0,         32'hFFFF8001, 2'b00, 1, 1, 4};
    vecs[8]  = '{1, 0, 0, 3'b000, 32'hCAFEF00D, 32'h0,         5'd31, 1, 32'h0,        0,  0, 0, 10'h000, 4'b0000, 32'h0,         32'h0,        2'b00, 1, 0, 0};
    vecs[9]  = '{1, 1, 0, 3'b101, 32'h00000020, 32'h0,         5'd5,  0, 32'h8001F00F, 1,  1, 0, 10'h008, 4'b0011, 32'h0,         32'h0000F00F, 2'b00, 1, 1, 2};
    vecs[10] = '{0, 0, 1, 3'b000, 32'h00000041, 32'h000000A5,  5'd0,  0, 32'h0,        0,  1, 1, 10'h010, 4'b0010, 32'hA5A5A5A5,  32'h0,        2'b00, 0, 0, 1};
    vecs[11] = '{1, 1, 0, 3'b010, 32'h00000044, 32'h0,         5'd9,  0, 32'h0,        99, 1, 0, 10'h011, 4'b1111, 32'h0,         32'h0,        2'b10, 0, 0, 4};
    vecs[12] = '{0, 0, 1, 3'b010, 32'h000003FC, 32'h01020304,  5'd0,  0, 32'h0,        2,  1, 1, 10'h0FF, 4'b1111, 32'h01020304,  32'h0,        2'b00, 0, 0, 3};
    vecs[13] = '{1, 1, 0, 3'b001, 32'h00000005, 32'h0,         5'd10, 0, 32'h0,        0,  0, 0, 10'h000, 4'b0000, 32'h0,         32'h0,        2'b01, 0, 0, 0};
    vecs[14] = '{1, 1, 0, 3'b000, 32'h00000000, 32'h0,         5'd11, 0, 32'h0000007F, 0,  1, 0, 10'h000, 4'b0001, 32'h0,         32'h0000007F, 2'b00, 1, 1, 1};
    vecs[15] = '{1, 1, 0, 3'b010, 32'h00001004, 32'h0,         5'd12, 0, 32'h12345678, 0,  1, 0, 10'h001, 4'b1111, 32'h0,         32'h12345678, 2'b00, 1, 1, 1};
    vecs[16] = '{1, 1, 0, 3'b001, 32'h00000002, 32'h0,         5'd13, 1, 32'hABCD1234, 0,  1, 0, 10'h000, 4'b1100, 32'h0,         32'hFFFFABCD, 2'b00, 1, 1, 1};

    reset = 0;
    drive_bubble();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset asserted while a load is waiting on ready: nothing may come out.
    @(negedge clk);
    RegWriteIn = 1; MemtoRegIn = 1; MemWriteIn = 0; MemOpIn = 3'b010;
    ALUResultIn = 32'h8; WriteRegIn = 5'd6; HaltIn = 1; dmem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreq_req_high", 32'(dmem_req), 32'd1);
    chk("midreq_stall_high", 32'(Stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    drive_bubble();
    @(posedge clk); #1;
    chk_all_zero("midreq_reset");
    @(negedge clk);
    reset = 1;

    run_vec(6);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
